reverb_comb_stage: RTL and testbench

REVERB_COMB_STAGE -- requirements
Module: reverb_comb_stage

---
 rtl/reverb_pkg.sv | 22 ++
 rtl/reverb_delay_line.sv | 22 ++
 rtl/reverb_comb_stage.sv | 123 ++++++++++++
 tb/tb_reverb_comb_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reverb_pkg.sv
// reverb_pkg: state encoding, fixed-point constants and the saturation helper
// shared by the reverb stages.
package reverb_pkg;

    typedef enum logic [1:0] {IDLE, MUL, ADD, OUT} state_e;

    localparam int FRAC = 8;

    // Clamp limits at the default 24-bit sample width
    localparam logic [23:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [23:0] SAT_MIN = 24'h800000;

    // Returns {positive overflow, negative overflow} of v against a signed n-bit range
    function automatic logic [1:0] sat_flags(input logic signed [63:0] v, input int unsigned n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return {v > hi, v < lo};
    endfunction

endpackage

// File: rtl/reverb_delay_line.sv
// reverb_delay_line: DEPTH x N echo memory with one write port and a
// combinational read port sharing the same address.
module reverb_delay_line #(
    parameter int N     = 24,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];

endmodule

// File: rtl/reverb_comb_stage.sv
// reverb_comb_stage: feedback comb filter y[n] = sat(x[n] + sat(g * y[n-DEPTH]))
// run as a four-state IDLE/MUL/ADD/OUT handshake around a DEPTH-sample delay line.
module reverb_comb_stage #(
    parameter int N     = 24,
    parameter int FRAC  = reverb_pkg::FRAC,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [N-1:0] in_gain,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_sat
);

    import reverb_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

    state_e state_q, state_d;
    logic signed [N-1:0] x_q, x_d, g_q, g_d, e_q, e_d, p_q, p_d, y_q, y_d;
    logic psat_q, psat_d, sat_q, sat_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [N-1:0] rd_data;
    logic we;
    logic signed [2*N-1:0] prod;
    logic signed [N:0] sum;
    logic signed [63:0] prod_w, sum_w;
    logic [1:0] prod_f, sum_f;

    assign prod   = g_q * e_q;
    assign prod_w = 64'(prod >>> FRAC);
    assign prod_f = sat_flags(prod_w, N);
    assign sum    = {x_q[N-1], x_q} + {p_q[N-1], p_q};
    assign sum_w  = 64'(sum);
    assign sum_f  = sat_flags(sum_w, N);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        g_d      = g_q;
        e_d      = e_q;
        p_d      = p_q;
        psat_d   = psat_q;
        y_d      = y_q;
        sat_d    = sat_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        we       = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d     = in_data;
                g_d     = in_gain;
                // Unwritten entries read as silence until the line has filled once
                e_d     = fill_q == FW'(DEPTH) ? rd_data : '0;
                state_d = MUL;
            end
            MUL: begin
                p_d     = prod_f[1] ? SMAX : prod_f[0] ? SMIN : prod_w[N-1:0];
                psat_d  = |prod_f;
                state_d = ADD;
            end
            ADD: begin
                y_d      = sum_f[1] ? SMAX : sum_f[0] ? SMIN : sum_w[N-1:0];
                sat_d    = psat_q | (|sum_f);
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                fill_d   = fill_q == FW'(DEPTH) ? fill_q : fill_q + 1'b1;
                state_d  = OUT;
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            g_q      <= '0;
            e_q      <= '0;
            p_q      <= '0;
            psat_q   <= 1'b0;
            y_q      <= '0;
            sat_q    <= 1'b0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            g_q      <= g_d;
            e_q      <= e_d;
            p_q      <= p_d;
            psat_q   <= psat_d;
            y_q      <= y_d;
            sat_q    <= sat_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    reverb_delay_line #(.N(N), .DEPTH(DEPTH)) u_delay (
        .clk   (clk),
        .we    (we),
        .addr  (wr_ptr_q),
        .wdata (y_d),
        .rdata (rd_data)
    );

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign out_data  = y_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_reverb_comb_stage.sv
// tb_reverb_comb_stage: directed vectors for three comb stages (DEPTH 4, 2, 8)
// plus hand-written backpressure, mid-operation reset and wrap sequences.
module tb_reverb_comb_stage;

    import reverb_pkg::*;

    typedef struct {
        bit          rst;
        int          k;
        logic [23:0] x;
        logic [23:0] g;
        logic [23:0] y;
        logic        s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid [3];
    logic        in_ready [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        out_sat [3];
    logic [23:0] in_data [3];
    logic [23:0] in_gain [3];
    logic [23:0] out_data [3];

    int   checks = 0;
    int   errors = 0;
    vec_t tab[$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        reverb_comb_stage #(.N(24), .FRAC(8), .DEPTH(i == 0 ? 4 : i == 1 ? 2 : 8)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[i]),
            .in_ready  (in_ready[i]),
            .in_data   (in_data[i]),
            .in_gain   (in_gain[i]),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .out_data  (out_data[i]),
            .out_sat   (out_sat[i])
        );
    end

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input bit r, input int k, input logic [23:0] x, input logic [23:0] g,
                       input logic [23:0] y, input logic s);
        vec_t v;
        v.rst = r;
        v.k   = k;
        v.x   = x;
        v.g   = g;
        v.y   = y;
        v.s   = s;
        tab.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one sample, wait for its output, sample it, then complete the handshake
    task automatic xfer(input int k, input logic [23:0] x, input logic [23:0] g,
                        output logic [23:0] y, output logic s);
        int n;
        @(negedge clk);
        chk($sformatf("in_ready idle k%0d", k), 24'(in_ready[k]), 24'h1);
        in_valid[k] = 1'b1;
        in_data[k]  = x;
        in_gain[k]  = g;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        n = 0;
        while (!out_valid[k] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency k%0d", k), 24'(n), 24'd2);
        y = out_data[k];
        s = out_sat[k];
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic run_tab(input int lo, input int hi, input bit allow_rst);
        logic [23:0] y;
        logic        s;
        for (int i = lo; i <= hi; i++) begin
            if (tab[i].rst && allow_rst) do_reset();
            xfer(tab[i].k, tab[i].x, tab[i].g, y, s);
            chk($sformatf("vec%0d data", i), y, tab[i].y);
            chk($sformatf("vec%0d sat", i), 24'(s), 24'(tab[i].s));
        end
    endtask

    function automatic longint clip(input longint v, output bit f);
        f = v > 64'sd8388607 || v < -64'sd8388608;
        return v > 64'sd8388607 ? 64'sd8388607 : v < -64'sd8388608 ? -64'sd8388608 : v;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] y;
        logic        s;
        int          n;
        longint      yh [20];
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_data[i]   = '0;
            in_gain[i]   = '0;
        end

        // Reset state while rst_n is held low
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst in_ready k%0d", i), 24'(in_ready[i]), 24'h1);
            chk($sformatf("rst out_valid k%0d", i), 24'(out_valid[i]), 24'h0);
            chk($sformatf("rst out_data k%0d", i), out_data[i], 24'h0);
            chk($sformatf("rst out_sat k%0d", i), 24'(out_sat[i]), 24'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 0..11 impulse, DEPTH 4, g = 0.5
        for (int i = 0; i < 12; i++)
            add(i == 0, 0, i == 0 ? 24'h100 : 24'h0, 24'h000080,
                i == 0 ? 24'h100 : i == 4 ? 24'h80 : i == 8 ? 24'h40 : 24'h0, 1'b0);
        // 12..20 negative feedback, DEPTH 4, g = -0.5
        for (int i = 0; i < 9; i++)
            add(i == 0, 0, i == 0 ? 24'h100 : 24'h0, 24'hFFFF80,
                i == 0 ? 24'h100 : i == 4 ? 24'hFFFF80 : i == 8 ? 24'h40 : 24'h0, 1'b0);
        // 21..29 saturation on DEPTH 2: sum positive, sum negative, product overflow
        add(1, 1, 24'h7FFF00, 24'h000100, 24'h7FFF00, 1'b0);
        add(0, 1, 24'h0,      24'h000100, 24'h0,      1'b0);
        add(0, 1, 24'h7FFF00, 24'h000100, SAT_MAX,    1'b1);
        add(1, 1, 24'h800100, 24'h000100, 24'h800100, 1'b0);
        add(0, 1, 24'h0,      24'h000100, 24'h0,      1'b0);
        add(0, 1, 24'h800100, 24'h000100, SAT_MIN,    1'b1);
        add(1, 1, 24'h100000, 24'h010000, 24'h100000, 1'b0);
        add(0, 1, 24'h0,      24'h010000, 24'h0,      1'b0);
        add(0, 1, 24'h0,      24'h010000, SAT_MAX,    1'b1);
        run_tab(0, 29, 1);

        // Backpressure: stall 5+ cycles in OUT while a competing sample is offered
        do_reset();
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 24'h100;
        in_gain[0]  = 24'h80;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        in_valid[0] = 1'b1;
        in_data[0]  = 24'h005555;
        for (int c = 0; c < 6; c++) begin
            chk("stall out_valid", 24'(out_valid[0]), 24'h1);
            chk("stall out_data", out_data[0], 24'h100);
            chk("stall in_ready", 24'(in_ready[0]), 24'h0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        for (int i = 1; i < 8; i++) begin
            xfer(0, 24'h0, 24'h80, y, s);
            chk($sformatf("post-stall n%0d", i), y, i == 4 ? 24'h80 : 24'h0);
        end

        // Reset asserted while the second sample sits in ADD
        do_reset();
        xfer(0, 24'h100, 24'h80, y, s);
        chk("pre-abort y0", y, 24'h100);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 24'h0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort in_ready", 24'(in_ready[0]), 24'h1);
        chk("abort out_valid", 24'(out_valid[0]), 24'h0);
        chk("abort out_data", out_data[0], 24'h0);
        chk("abort out_sat", 24'(out_sat[0]), 24'h0);
        @(negedge clk);
        chk("abort hold out_data", out_data[0], 24'h0);
        rst_n = 1'b1;
        run_tab(0, 11, 0);

        // Ramp through several pointer wraps on DEPTH 8, g = 0.25
        do_reset();
        for (int i = 0; i < 20; i++) begin
            longint e, p, sm;
            bit     pf, sf;
            e  = i >= 8 ? yh[i-8] : 64'sd0;
            p  = clip((64'sd64 * e) >>> 8, pf);
            sm = clip(longint'(256 * i) + p, sf);
            yh[i] = sm;
            xfer(2, 24'(256 * i), 24'h000040, y, s);
            chk($sformatf("ramp n%0d data", i), y, sm[23:0]);
            chk($sformatf("ramp n%0d sat", i), 24'(s), 24'(pf | sf));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
